mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
//  Runs load/store accesses against the external data memory over a req/ack handshake.
//  Stalls the upstream pipe while an access is outstanding; flags misaligned accesses and access timeouts.
//  Registers the results for write-back.
// PARAMETERS
//  n          32  datapath width (address, data)
//  RA_W       5   register-file address width
//  TIMEOUT    16  max cycles in REQ without mem_ack before bus error (>=1)
//  TO_W       5   timeout counter width (must hold TIMEOUT)
// PORTS
//  clk            in   1     clock, all state on posedge
//  reset_in       in   1     synchronous, active-high reset
//  RegWrite_in    in   1     EX/MEM control: write register file
//  MemtoReg_in    in   1     EX/MEM control: WB selects memory data
//  MemRead_in     in   1     EX/MEM control: load
//  MemWrite_in    in   1     EX/MEM control: store
//  ALU_Result_in  in   n     EX/MEM: address for ld/st, else result
//  RT_data_in     in   n     EX/MEM: store data
//  WriteReg_in    in   RA_W  EX/MEM: destination register
//  mem_req        out  1     memory request, high for the whole of REQ
//  mem_we         out  1     1=write, 0=read; valid while mem_req
//  mem_addr       out  n     = ALU_Result_in, word aligned
//  mem_wdata      out  n     = RT_data_in
//  mem_ack        in   1     one-cycle completion; mem_rdata valid with it
//  mem_rdata      in   n     load data
//  stall_out      out  1     hold EX/MEM and earlier stages this cycle
//  RegWrite_out   out  1     MEM/WB: write enable to WB
//  MemtoReg_out   out  1     MEM/WB: WB mux select
//  ReadData_out   out  n     MEM/WB: load data
//  ALU_Result_out out  n     MEM/WB: ALU result
//  WriteReg_out   out  RA_W  MEM/WB: destination register
//  align_err      out  1     one-cycle pulse: misaligned ld/st dropped
//  bus_err        out  1     sticky: access timed out; cleared only by reset
// BEHAVIOUR
//  Reset:
//   - state=IDLE, counter=0; all registered outputs 0, including bus_err and align_err.
//   - mem_req=0 and stall_out=0 in the cycle after the reset edge.
//   - An in-flight access is abandoned; a late mem_ack in IDLE is ignored.
//  op = MemRead_in|MemWrite_in; mis = op & (ALU_Result_in[1:0]!=0).
//   - MemRead_in and MemWrite_in both high is treated as a store.
//  IDLE, !op:
//   - MEM/WB captures RegWrite/MemtoReg/ALU_Result/WriteReg; ReadData_out<=0.
//   - stall_out=0.
//  IDLE, mis:
//   - no request; align_err<=1 for one cycle; MEM/WB captures with RegWrite_out<=0.
//   - stall_out=0.
//  IDLE, op & !mis:
//   - stall_out=1; bubble into MEM/WB (RegWrite_out<=0, MemtoReg_out<=0); next=REQ; counter<=0.
//  REQ:
//   - mem_req=1; mem_we/mem_addr/mem_wdata driven combinationally from the held inputs.
//   - stall_out = !mem_ack.
//   - mem_ack: MEM/WB captures controls and ALU_Result; ReadData_out<=mem_rdata on a load (0 on a store).
//     next=IDLE; upstream advances on this edge.
//   - no ack: counter++. When counter==TIMEOUT-1 without ack: treat as completion with ReadData_out<=0
//     and RegWrite_out<=0; bus_err<=1; next=IDLE; stall_out=0 that cycle.
//  Latency:
//   - non-mem op: 1 cycle to MEM/WB.
//   - ld/st: 1 + k cycles, where ack arrives in the k-th REQ cycle (min 2).
//   - Exactly one bubble per access.
//  mem_req never drops before ack or timeout. A second access never issues back-to-back without an IDLE cycle.
// TESTING
//  1 ALU op, RegWrite_in=1, ALU_Result_in=0x1234, WriteReg_in=5 -> next cycle RegWrite_out=1, ALU_Result_out=0x1234, WriteReg_out=5, stall_out=0 throughout.
//  2 Load addr 0x40, mem_ack 3rd REQ cycle, rdata 0xDEADBEEF -> stall high 3 cycles, mem_req high 3, one bubble, then ReadData_out=0xDEADBEEF, MemtoReg_out=1.
//  3 Store addr 0x80, RT_data 0xA5A5A5A5, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5 in REQ; stall 1 cycle; RegWrite_out=0.
//  4 Load addr 0x42 -> no mem_req, align_err one pulse, RegWrite_out=0, no stall.
//  5 Load, ack never arrives, TIMEOUT=16 -> mem_req high exactly 16 cycles, bus_err=1 and stays, stall released, RegWrite_out=0.
//  6 reset_in asserted in 2nd REQ cycle, ack next cycle -> mem_req=0, all outputs 0, late ack ignored, state IDLE.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM stage plus MEM/WB pipeline register. Issues load/store accesses from the
// EX/MEM register to an external data memory over a req/ack handshake, stalls
// the upstream pipe while an access is outstanding, drops misaligned accesses
// (align_err pulse) and turns a missing ack into a sticky bus_err.
//
// Ports
//   clk, reset_in                    clock, synchronous active-high reset
//   RegWrite_in .. WriteReg_in       EX/MEM register contents (held while stalled)
//   mem_req/we/addr/wdata            memory request side (combinational from state)
//   mem_ack, mem_rdata               one-cycle completion with load data
//   stall_out                        hold EX/MEM and earlier stages this cycle
//   RegWrite_out .. WriteReg_out     MEM/WB register contents
//   align_err                        one-cycle pulse, misaligned access dropped
//   bus_err                          sticky access-timeout flag, cleared by reset only
module mem_wb_stage #(
    parameter int n       = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic            clk,
    input  logic            reset_in,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic [n-1:0]    ALU_Result_in,
    input  logic [n-1:0]    RT_data_in,
    input  logic [RA_W-1:0] WriteReg_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [n-1:0]    mem_addr,
    output logic [n-1:0]    mem_wdata,
    input  logic            mem_ack,
    input  logic [n-1:0]    mem_rdata,
    output logic            stall_out,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic [n-1:0]    ReadData_out,
    output logic [n-1:0]    ALU_Result_out,
    output logic [RA_W-1:0] WriteReg_out,
    output logic            align_err,
    output logic            bus_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TO_W-1:0] cnt_r;

    logic            op_s;
    logic            mis_s;
    logic            is_load_s;
    logic            timeout_s;

    logic            reg_write_r;
    logic            mem_to_reg_r;
    logic [n-1:0]    read_data_r;
    logic [n-1:0]    alu_result_r;
    logic [RA_W-1:0] write_reg_r;
    logic            align_err_r;
    logic            bus_err_r;

    // Access decode; read+write together is a store, so only a pure read loads.
    always_comb begin
        op_s      = MemRead_in | MemWrite_in;
        mis_s     = op_s & (ALU_Result_in[1:0] != 2'b00);
        is_load_s = MemRead_in & ~MemWrite_in;
        timeout_s = (state_r == S_REQ) & ~mem_ack & (cnt_r == TO_W'(TIMEOUT - 1));
    end

    // Request payload follows the EX/MEM register, which is frozen while stalled.
    assign mem_addr  = {ALU_Result_in[n-1:2], 2'b00};
    assign mem_wdata = RT_data_in;

    // State register.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one REQ episode per aligned access, always back through IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (op_s && !mis_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ack || timeout_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Handshake and stall outputs. Stall drops in the completing cycle so the
    // upstream pipe advances on the same edge that loads MEM/WB.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall_out = 1'b0;
        case (state_r)
            S_IDLE: begin
                stall_out = op_s & ~mis_s;
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = MemWrite_in;
                stall_out = ~mem_ack & ~timeout_s;
            end
            default: begin
                mem_req   = 1'b0;
                mem_we    = 1'b0;
                stall_out = 1'b0;
            end
        endcase
    end

    // MEM/WB register, timeout counter and error flags.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            cnt_r        <= '0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            read_data_r  <= '0;
            alu_result_r <= '0;
            write_reg_r  <= '0;
            align_err_r  <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            align_err_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= '0;
                    if (!op_s) begin
                        reg_write_r  <= RegWrite_in;
                        mem_to_reg_r <= MemtoReg_in;
                        read_data_r  <= '0;
                        alu_result_r <= ALU_Result_in;
                        write_reg_r  <= WriteReg_in;
                    end else if (mis_s) begin
                        // Dropped access: keep the slot but never write the register file.
                        reg_write_r  <= 1'b0;
                        mem_to_reg_r <= MemtoReg_in;
                        read_data_r  <= '0;
                        alu_result_r <= ALU_Result_in;
                        write_reg_r  <= WriteReg_in;
                        align_err_r  <= 1'b1;
                    end else begin
                        // The single bubble for this access; it stays put until completion.
                        reg_write_r  <= 1'b0;
                        mem_to_reg_r <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        cnt_r        <= '0;
                        reg_write_r  <= RegWrite_in;
                        mem_to_reg_r <= MemtoReg_in;
                        read_data_r  <= is_load_s ? mem_rdata : '0;
                        alu_result_r <= ALU_Result_in;
                        write_reg_r  <= WriteReg_in;
                    end else if (timeout_s) begin
                        cnt_r        <= '0;
                        reg_write_r  <= 1'b0;
                        mem_to_reg_r <= MemtoReg_in;
                        read_data_r  <= '0;
                        alu_result_r <= ALU_Result_in;
                        write_reg_r  <= WriteReg_in;
                        bus_err_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + TO_W'(1);
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign RegWrite_out   = reg_write_r;
    assign MemtoReg_out   = mem_to_reg_r;
    assign ReadData_out   = read_data_r;
    assign ALU_Result_out = alu_result_r;
    assign WriteReg_out   = write_reg_r;
    assign align_err      = align_err_r;
    assign bus_err        = bus_err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. Inputs change and outputs are sampled on the
// falling clock edge; combinational outputs are sampled #1 after input changes.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset_in;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [31:0] ALU_Result_in, RT_data_in;
    logic [4:0]  WriteReg_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_out;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] ReadData_out, ALU_Result_out;
    logic [4:0]  WriteReg_out;
    logic        align_err, bus_err;

    int passed = 0;
    int total  = 0;

    mem_wb_stage #(.n(32), .RA_W(5), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset_in(reset_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALU_Result_in(ALU_Result_in), .RT_data_in(RT_data_in),
        .WriteReg_in(WriteReg_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_out(stall_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .ReadData_out(ReadData_out), .ALU_Result_out(ALU_Result_out),
        .WriteReg_out(WriteReg_out),
        .align_err(align_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        RegWrite_in   = 1'b0;
        MemtoReg_in   = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        ALU_Result_in = 32'h0;
        RT_data_in    = 32'h0;
        WriteReg_in   = 5'd0;
    endtask

    initial begin
        int req_cnt;
        logic stall_last;
        reset_in  = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b0;
        #1;
        chk("rst_req",      32'(mem_req), 32'd0);
        chk("rst_stall",    32'(stall_out), 32'd0);
        chk("rst_regwrite", 32'(RegWrite_out), 32'd0);
        chk("rst_alu",      ALU_Result_out, 32'h0);
        chk("rst_buserr",   32'(bus_err), 32'd0);
        chk("rst_alignerr", 32'(align_err), 32'd0);

        // 1: ALU op passes straight through in one cycle
        @(negedge clk);
        RegWrite_in = 1'b1; ALU_Result_in = 32'h1234; WriteReg_in = 5'd5;
        #1;
        chk("t1_stall_in", 32'(stall_out), 32'd0);
        @(negedge clk);
        chk("t1_regwrite", 32'(RegWrite_out), 32'd1);
        chk("t1_alu",      ALU_Result_out, 32'h1234);
        chk("t1_wreg",     32'(WriteReg_out), 32'd5);
        chk("t1_stall",    32'(stall_out), 32'd0);

        // 2: load at 0x40, ack in the 3rd REQ cycle
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1;
        ALU_Result_in = 32'h40; WriteReg_in = 5'd7;
        #1;
        chk("t2_stall_idle", 32'(stall_out), 32'd1);
        chk("t2_req_idle",   32'(mem_req), 32'd0);
        @(negedge clk);
        chk("t2_req1",      32'(mem_req), 32'd1);
        chk("t2_stall1",    32'(stall_out), 32'd1);
        chk("t2_we",        32'(mem_we), 32'd0);
        chk("t2_addr",      mem_addr, 32'h40);
        chk("t2_bubble_rw", 32'(RegWrite_out), 32'd0);
        chk("t2_bubble_mr", 32'(MemtoReg_out), 32'd0);
        @(negedge clk);
        chk("t2_req2",   32'(mem_req), 32'd1);
        chk("t2_stall2", 32'(stall_out), 32'd1);
        chk("t2_bubble_hold", 32'(RegWrite_out), 32'd0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t2_req3",   32'(mem_req), 32'd1);
        chk("t2_stall3", 32'(stall_out), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        idle_inputs();
        #1;
        chk("t2_rdata",    ReadData_out, 32'hDEADBEEF);
        chk("t2_memtoreg", 32'(MemtoReg_out), 32'd1);
        chk("t2_regwrite", 32'(RegWrite_out), 32'd1);
        chk("t2_wreg",     32'(WriteReg_out), 32'd7);
        chk("t2_req_off",  32'(mem_req), 32'd0);

        // 3: store (read+write both set) with immediate ack
        MemRead_in = 1'b1; MemWrite_in = 1'b1;
        ALU_Result_in = 32'h80; RT_data_in = 32'hA5A5A5A5;
        #1;
        chk("t3_stall_idle", 32'(stall_out), 32'd1);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        #1;
        chk("t3_req",   32'(mem_req), 32'd1);
        chk("t3_we",    32'(mem_we), 32'd1);
        chk("t3_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("t3_addr",  mem_addr, 32'h80);
        chk("t3_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        idle_inputs();
        #1;
        chk("t3_regwrite", 32'(RegWrite_out), 32'd0);
        chk("t3_rdata",    ReadData_out, 32'h0);
        chk("t3_alu",      ALU_Result_out, 32'h80);
        chk("t3_req_off",  32'(mem_req), 32'd0);

        // 4: misaligned load is dropped with an align_err pulse
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1;
        ALU_Result_in = 32'h42; WriteReg_in = 5'd9;
        #1;
        chk("t4_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        chk("t4_align",    32'(align_err), 32'd1);
        chk("t4_regwrite", 32'(RegWrite_out), 32'd0);
        chk("t4_alu",      ALU_Result_out, 32'h42);
        chk("t4_req",      32'(mem_req), 32'd0);
        idle_inputs();
        RegWrite_in = 1'b1; ALU_Result_in = 32'h55; WriteReg_in = 5'd3;
        @(negedge clk);
        chk("t4_align_off", 32'(align_err), 32'd0);
        chk("t4_next_rw",   32'(RegWrite_out), 32'd1);
        chk("t4_next_alu",  ALU_Result_out, 32'h55);

        // 5: load with no ack times out after 16 REQ cycles
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1;
        ALU_Result_in = 32'h100; WriteReg_in = 5'd4;
        req_cnt = 0;
        stall_last = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            req_cnt++;
            if (req_cnt == 1) chk("t5_buserr_pre", 32'(bus_err), 32'd0);
            if (req_cnt == 16) stall_last = stall_out;
        end
        idle_inputs();
        #1;
        chk("t5_req_cycles", 32'(req_cnt), 32'd16);
        chk("t5_stall_last", 32'(stall_last), 32'd0);
        chk("t5_buserr",     32'(bus_err), 32'd1);
        chk("t5_regwrite",   32'(RegWrite_out), 32'd0);
        chk("t5_rdata",      ReadData_out, 32'h0);
        chk("t5_stall_off",  32'(stall_out), 32'd0);
        @(negedge clk);
        chk("t5_buserr_sticky", 32'(bus_err), 32'd1);
        chk("t5_req_off",       32'(mem_req), 32'd0);

        // 6: reset in the 2nd REQ cycle; the late ack is ignored
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1;
        ALU_Result_in = 32'h200; WriteReg_in = 5'd6;
        @(negedge clk);
        chk("t6_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("t6_req2", 32'(mem_req), 32'd1);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("t6_req_off",  32'(mem_req), 32'd0);
        chk("t6_stall",    32'(stall_out), 32'd0);
        chk("t6_buserr",   32'(bus_err), 32'd0);
        chk("t6_regwrite", 32'(RegWrite_out), 32'd0);
        chk("t6_alu",      ALU_Result_out, 32'h0);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("t6_late_ack_rdata", ReadData_out, 32'h0);
        chk("t6_late_ack_req",   32'(mem_req), 32'd0);
        chk("t6_late_ack_mr",    32'(MemtoReg_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
